// File: rtl/movegen_piece_iter.sv
// movegen_piece_iter
//   Snoops the serial position load bus and keeps one piece list per colour
//   (DEPTH entries each, load order). On start it streams the side-to-move's
//   list as {piece, rank, file} beats over valid/ready with sop/eop framing.
//   With ORDERED=1 the stream is grouped by piece code 1..6, and load order is
//   kept within each group.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_pos_*              position load bus (valid/ready, 4-bit data, sop/eop)
//   in_wtp, start         colour select (sampled at start), iterate request
//   out_*                 beat stream {piece[2:0], rank[2:0], file[2:0]}
//   iter_done             one-cycle pulse once an iteration is finished
//   count_w/count_b       entries stored per colour
//   overflow, pos_err     sticky flags, cleared by the next sop beat
module movegen_piece_iter #(
    parameter int  DEPTH   = 16,
    parameter int  ORDERED = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_pos_valid,
    input  logic [3:0]    in_pos_data,
    input  logic          in_pos_sop,
    input  logic          in_pos_eop,
    output logic          in_pos_ready,
    input  logic          in_wtp,
    input  logic          start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [8:0]    out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic          iter_done,
    output logic [CW-1:0] count_w,
    output logic [CW-1:0] count_b,
    output logic          overflow,
    output logic          pos_err
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_ITER} state_t;

    state_t state, state_nx;

    logic [8:0] list_w [DEPTH];
    logic [8:0] list_b [DEPTH];
    logic [5:0] sq_cnt;

    // ---------------- load side ----------------
    logic          beat_acc, sop_acc, load_beat, bad_beat;
    logic          load_end_ok, load_end_bad;
    logic [5:0]    sq;
    logic [2:0]    pc;
    logic          white;
    logic [CW-1:0] base_w, base_b;
    logic          add_w, add_b, drop;

    assign in_pos_ready = (state != S_ITER);
    assign beat_acc     = in_pos_valid && in_pos_ready;
    assign sop_acc      = beat_acc && in_pos_sop;
    assign load_beat    = sop_acc || (beat_acc && state == S_LOAD);
    // A stray beat outside a load is dropped but flagged.
    assign bad_beat     = beat_acc && !in_pos_sop && (state == S_IDLE || state == S_READY);
    assign sq           = in_pos_sop ? 6'd0 : sq_cnt;
    assign pc           = in_pos_data[2:0];
    assign white        = in_pos_data[3];

    // A sop beat restarts the lists, so its own append sees empty counts.
    assign base_w = sop_acc ? '0 : count_w;
    assign base_b = sop_acc ? '0 : count_b;
    assign add_w  = load_beat && pc != 3'd0 && white  && base_w != DEPTH_C;
    assign add_b  = load_beat && pc != 3'd0 && !white && base_b != DEPTH_C;
    assign drop   = load_beat && pc != 3'd0 &&
                    ((white && base_w == DEPTH_C) || (!white && base_b == DEPTH_C));

    // Square 63 must carry eop; anything else ends the load as malformed.
    assign load_end_ok  = load_beat && in_pos_eop && sq == 6'd63;
    assign load_end_bad = load_beat && (in_pos_eop != (sq == 6'd63));

    // ---------------- iterate side ----------------
    logic          sel_w;
    logic [IW-1:0] scan_idx;
    logic [2:0]    scan_type;
    logic          scan_end;
    logic          la_valid;
    logic [8:0]    la_data;
    logic          first;

    logic [8:0]    entry;
    logic [CW-1:0] cnt_sel;
    logic          scanning, m, out_free, la_to_out, la_free, scan_adv, last_idx;
    logic          start_go, done_cond;

    assign start_go  = start && state == S_READY && !sop_acc;
    assign entry     = sel_w ? list_w[scan_idx] : list_b[scan_idx];
    assign cnt_sel   = sel_w ? count_w : count_b;
    assign scanning  = state == S_ITER && !scan_end;
    assign m         = scanning && (ORDERED == 0 || entry[8:6] == scan_type);
    assign out_free  = !out_valid || out_ready;
    // The lookahead entry may only move out once its eop status is known:
    // either the scanner has another match in hand, or it has run dry.
    assign la_to_out = state == S_ITER && la_valid && (m || scan_end) && out_free;
    assign la_free   = !la_valid || la_to_out;
    assign scan_adv  = scanning && (!m || la_free);
    assign last_idx  = (CW'(scan_idx) + CW'(1)) == cnt_sel;
    // Finished: eop just transferred, or nothing was ever found.
    assign done_cond = state == S_ITER &&
                       ((out_valid && out_ready && out_eop) ||
                        (!out_valid && !la_valid && scan_end));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (load_end_ok)       state_nx = S_READY;
        else if (load_end_bad) state_nx = S_IDLE;
        else if (sop_acc)      state_nx = S_LOAD;
        else if (start_go)     state_nx = S_ITER;
        else if (done_cond)    state_nx = S_READY;
    end

    // ---------------- load registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_w  <= '0;
            count_b  <= '0;
            sq_cnt   <= '0;
            overflow <= 1'b0;
            pos_err  <= 1'b0;
        end else begin
            if (load_beat) begin
                count_w  <= base_w + CW'(add_w);
                count_b  <= base_b + CW'(add_b);
                sq_cnt   <= sq + 6'd1;
                overflow <= (overflow && !sop_acc) || drop;
            end
            if (sop_acc)                        pos_err <= load_end_bad;
            else if (load_end_bad || bad_beat)  pos_err <= 1'b1;
        end
    end

    // List storage needs no reset: counts gate every read.
    always_ff @(posedge clk) begin
        if (add_w) list_w[base_w[IW-1:0]] <= {pc, sq};
        if (add_b) list_b[base_b[IW-1:0]] <= {pc, sq};
    end

    // ---------------- scanner / lookahead / output ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_w     <= 1'b0;
            scan_idx  <= '0;
            scan_type <= 3'd1;
            scan_end  <= 1'b0;
            la_valid  <= 1'b0;
            la_data   <= '0;
            first     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            iter_done <= 1'b0;
        end else begin
            iter_done <= 1'b0;
            if (start_go) begin
                sel_w     <= in_wtp;
                scan_idx  <= '0;
                scan_type <= 3'd1;
                scan_end  <= in_wtp ? (count_w == '0) : (count_b == '0);
                la_valid  <= 1'b0;
                first     <= 1'b1;
                out_valid <= 1'b0;
            end else if (state == S_ITER) begin
                if (scan_adv) begin
                    if (last_idx) begin
                        scan_idx <= '0;
                        if (ORDERED == 0 || scan_type == 3'd6) scan_end  <= 1'b1;
                        else                                   scan_type <= scan_type + 3'd1;
                    end else begin
                        scan_idx <= scan_idx + IW'(1);
                    end
                end
                if (m && la_free) begin
                    la_valid <= 1'b1;
                    la_data  <= entry;
                end else if (la_to_out) begin
                    la_valid <= 1'b0;
                end
                if (la_to_out) begin
                    out_valid <= 1'b1;
                    out_data  <= la_data;
                    out_sop   <= first;
                    out_eop   <= scan_end;
                    first     <= 1'b0;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (done_cond) iter_done <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                la_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_movegen_piece_iter.sv
// Bench for movegen_piece_iter: drives one linear (ORDERED=0) and one grouped
// (ORDERED=1) instance from the same bus and checks both against a board model.
module tb_movegen_piece_iter;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_pos_valid = 1'b0, in_pos_sop = 1'b0, in_pos_eop = 1'b0;
    logic [3:0] in_pos_data = '0;
    logic in_wtp = 1'b0, start = 1'b0, out_ready = 1'b1;

    logic          ir[2], ov[2], osop[2], oeop[2], idone[2], ovf[2], perr[2];
    logic [8:0]    od[2];
    logic [CW-1:0] cw[2], cb[2];

    always #5 clk = ~clk;

    movegen_piece_iter #(.DEPTH(DEPTH), .ORDERED(0)) u_lin (
        .clk(clk), .rst_n(rst_n), .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
        .in_pos_sop(in_pos_sop), .in_pos_eop(in_pos_eop), .in_pos_ready(ir[0]),
        .in_wtp(in_wtp), .start(start), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_sop(osop[0]), .out_eop(oeop[0]), .iter_done(idone[0]),
        .count_w(cw[0]), .count_b(cb[0]), .overflow(ovf[0]), .pos_err(perr[0]));

    movegen_piece_iter #(.DEPTH(DEPTH), .ORDERED(1)) u_ord (
        .clk(clk), .rst_n(rst_n), .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
        .in_pos_sop(in_pos_sop), .in_pos_eop(in_pos_eop), .in_pos_ready(ir[1]),
        .in_wtp(in_wtp), .start(start), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_sop(osop[1]), .out_eop(oeop[1]), .iter_done(idone[1]),
        .count_w(cw[1]), .count_b(cb[1]), .overflow(ovf[1]), .pos_err(perr[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [3:0] board [64];
    logic [8:0] exp_q [2][64];
    int         exp_len [2];
    bit         no_iter = 1'b0;
    int         gen = 0;

    function automatic int model_cnt(input bit white);
        int n = 0;
        for (int s = 0; s < 64; s++)
            if (board[s][3] == white && board[s][2:0] != 3'd0) n++;
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    // Expected stream: side's pieces in square order, truncated to DEPTH;
    // the grouped variant is that list stably sorted by piece code.
    task automatic build_exp(input bit wtp, input bit idle);
        logic [8:0] lst[$];
        int n;
        lst = {};
        for (int s = 0; s < 64; s++)
            if (board[s][3] == wtp && board[s][2:0] != 3'd0 && lst.size() < DEPTH)
                lst.push_back({board[s][2:0], 6'(s)});
        exp_len[0] = lst.size();
        for (int i = 0; i < lst.size(); i++) exp_q[0][i] = lst[i];
        n = 0;
        for (int t = 1; t <= 6; t++)
            for (int i = 0; i < lst.size(); i++)
                if (lst[i][8:6] == 3'(t)) begin
                    exp_q[1][n] = lst[i];
                    n++;
                end
        exp_len[1] = n;
        if (idle) begin
            exp_len[0] = 0;
            exp_len[1] = 0;
        end
        no_iter = idle;
        gen++;
    endtask

    task automatic set_start_pos();
        logic [2:0] back [8];
        back = '{3'd3, 3'd5, 3'd4, 3'd2, 3'd1, 3'd4, 3'd5, 3'd3};
        for (int s = 0; s < 64; s++) board[s] = 4'h0;
        for (int f = 0; f < 8; f++) begin
            board[f]      = {1'b1, back[f]};
            board[8 + f]  = 4'b1110;
            board[48 + f] = 4'b0110;
            board[56 + f] = {1'b0, back[f]};
        end
    endtask

    // ---------------- compare process ----------------
    logic [8:0]  got [2][64];
    int          pos [2];
    int          done_seen [2];
    bit          st_v [2];
    logic [10:0] st_w [2];
    int          seen_gen = 0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0; done_seen[d] = 0; st_v[d] = 1'b0; st_w[d] = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            st_v[0] = 1'b0;
            st_v[1] = 1'b0;
        end else begin
            if (gen != seen_gen) begin
                seen_gen = gen;
                for (int d = 0; d < 2; d++) begin
                    pos[d]  = 0;
                    st_v[d] = 1'b0;
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (st_v[d]) begin
                    chk($sformatf("hold_valid%0d", d), 32'(ov[d]), 32'd1);
                    chk($sformatf("hold_data%0d", d), 32'({od[d], osop[d], oeop[d]}), 32'(st_w[d]));
                end
                if (ov[d] && out_ready) begin
                    if (pos[d] < exp_len[d]) begin
                        chk($sformatf("beat%0d_%0d", d, pos[d]), 32'(od[d]), 32'(exp_q[d][pos[d]]));
                        chk($sformatf("sop%0d_%0d", d, pos[d]), 32'(osop[d]), 32'(pos[d] == 0));
                        chk($sformatf("eop%0d_%0d", d, pos[d]), 32'(oeop[d]),
                            32'(pos[d] == exp_len[d] - 1));
                        got[d][pos[d]] = od[d];
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat%0d: got beat %0h beyond expected count %0d",
                                 d, od[d], exp_len[d]);
                    end
                    pos[d]++;
                end
                st_v[d] = ov[d] && !out_ready;
                st_w[d] = {od[d], osop[d], oeop[d]};
                if (idone[d]) begin
                    done_seen[d]++;
                    if (no_iter) begin
                        checks++;
                        errors++;
                        $display("FAIL iter_done_unexpected%0d: got 1 expected 0", d);
                    end else begin
                        chk($sformatf("beats_at_done%0d", d), 32'(pos[d]), 32'(exp_len[d]));
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    bit rnd = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic load_board(input int last);
        for (int s = 0; s <= last; s++) begin
            in_pos_valid = 1'b1;
            in_pos_data  = board[s];
            in_pos_sop   = (s == 0);
            in_pos_eop   = (s == last);
            @(posedge clk);
            #1;
        end
        in_pos_valid = 1'b0;
        in_pos_sop   = 1'b0;
        in_pos_eop   = 1'b0;
    endtask

    task automatic do_start(input bit wtp, input bit idle);
        build_exp(wtp, idle);
        in_wtp = wtp;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int b0, b1;
        bit ok;
        b0 = done_seen[0];
        b1 = done_seen[1];
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done_seen[0] > b0 && done_seen[1] > b1) ok = 1'b1;
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic chk_counts(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_cw%0d", tag, d), 32'(cw[d]), 32'(model_cnt(1'b1)));
            chk($sformatf("%s_cb%0d", tag, d), 32'(cb[d]), 32'(model_cnt(1'b0)));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        int d0, d1;
        for (int s = 0; s < 64; s++) board[s] = 4'h0;
        #22;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d), 32'(ir[d]), 32'd1);
            chk($sformatf("rst_valid%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rst_counts%0d", d), 32'({cw[d], cb[d]}), 32'd0);
            chk($sformatf("rst_flags%0d", d), 32'({ovf[d], perr[d], idone[d]}), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Start position, full rate, both colours.
        set_start_pos();
        load_board(63);
        chk("start_cw_lit", 32'(cw[0]), 32'd16);
        chk("start_cb_lit", 32'(cb[1]), 32'd16);
        chk_counts("start");
        chk("start_flags", 32'({ovf[0], perr[0], ovf[1], perr[1]}), 32'd0);
        do_start(1'b1, 1'b0);
        wait_done();
        chk("lin_w_first", 32'(got[0][0]), 32'(9'o300));
        chk("lin_w_second", 32'(got[0][1]), 32'(9'o501));
        chk("lin_w_last", 32'(got[0][15]), 32'(9'o617));
        do_start(1'b0, 1'b0);
        wait_done();
        chk("ord_b_0", 32'(got[1][0]), 32'(9'o174));
        chk("ord_b_1", 32'(got[1][1]), 32'(9'o273));
        chk("ord_b_2", 32'(got[1][2]), 32'(9'o370));
        chk("ord_b_3", 32'(got[1][3]), 32'(9'o377));
        chk("ord_b_4", 32'(got[1][4]), 32'(9'o472));
        chk("ord_b_last", 32'(got[1][15]), 32'(9'o667));

        // Random backpressure on the same position.
        rnd = 1'b1;
        do_start(1'b1, 1'b0);
        wait_done();
        do_start(1'b0, 1'b0);
        wait_done();
        rnd = 1'b0;
        @(posedge clk);
        #1;

        // Overflow: 17th white piece (pawn on a5, square 32) is dropped.
        board[32] = 4'b1110;
        load_board(63);
        chk("ovf_cw_lit", 32'(cw[0]), 32'd16);
        chk("ovf_flag0", 32'(ovf[0]), 32'd1);
        chk("ovf_flag1", 32'(ovf[1]), 32'd1);
        chk_counts("ovf");
        do_start(1'b1, 1'b0);
        wait_done();
        chk("ovf_last_beat", 32'(got[0][15]), 32'(9'o617));
        set_start_pos();
        load_board(63);
        chk("ovf_cleared0", 32'(ovf[0]), 32'd0);
        chk("ovf_cleared1", 32'(ovf[1]), 32'd0);

        // Malformed: eop at square 10.
        load_board(10);
        chk("mal_err0", 32'(perr[0]), 32'd1);
        chk("mal_err1", 32'(perr[1]), 32'd1);
        chk("mal_ready", 32'(ir[0]), 32'd1);
        d0 = done_seen[0];
        d1 = done_seen[1];
        do_start(1'b1, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("mal_no_done", 32'({done_seen[0] == d0, done_seen[1] == d1}), 32'd3);
        chk("mal_no_beats", 32'(pos[0] + pos[1]), 32'd0);

        // Empty side: only a white king on e1, iterate black.
        for (int s = 0; s < 64; s++) board[s] = 4'h0;
        board[4] = 4'b1001;
        load_board(63);
        chk("empty_perr", 32'(perr[0]), 32'd0);
        chk_counts("empty");
        do_start(1'b0, 1'b0);
        @(negedge clk);
        chk("empty_done_c1", 32'({idone[0], idone[1]}), 32'd0);
        @(negedge clk);
        chk("empty_done_c2", 32'({idone[0], idone[1]}), 32'd3);
        @(posedge clk);
        #1;
        chk("empty_no_beats", 32'(pos[0] + pos[1]), 32'd0);

        // Reset during the fifth beat.
        set_start_pos();
        load_board(63);
        do_start(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (pos[0] == 4 && ov[0]) found = 1'b1;
        end
        chk("reach_5th_beat", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid0", 32'(ov[0]), 32'd0);
        chk("arst_valid1", 32'(ov[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_rst_ready%0d", d), 32'(ir[d]), 32'd1);
            chk($sformatf("post_rst_counts%0d", d), 32'({cw[d], cb[d]}), 32'd0);
            chk($sformatf("post_rst_flags%0d", d), 32'({ovf[d], perr[d]}), 32'd0);
        end
        @(posedge clk);
        #1;
        d0 = done_seen[0];
        do_start(1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(done_seen[0] - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/movegen_piece_iter.md
Name: movegen_piece_iter

Overview:
- Parametrised successor to the fixed 16-slot piece stack / move-stack in the pseudo-legal board.
- Snoops the serial position load bus and builds one piece list per colour, DEPTH entries each.
- On start, streams the side-to-move's pieces as {piece, rank, file} beats over a valid/ready handshake, with sop/eop framing.
- Optional piece-type ordering (king first, pawns last). Overflow and malformed-load detection.
- Feeds the square-emit stage (onehot from rank/file) in place of the free-running move stack.

Parameters:
DEPTH, 16, entries per colour list (2..64)
ORDERED, 0, 0 = emit in load order; 1 = grouped by piece code 1..6 ascending, load order within a group
CW, $clog2(DEPTH+1), count width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_pos_valid  in  1  serial position beat valid
in_pos_data  in  4  {colour(1=white), piece[2:0]}; piece 0 none, 1 king, 2 queen, 3 rook, 4 bishop, 5 knight, 6 pawn
in_pos_sop  in  1  first beat (square 0)
in_pos_eop  in  1  last beat (must be square 63)
in_pos_ready  out  1  high except in ITER
in_wtp  in  1  sampled at start: 1 = iterate white list
start  in  1  single-cycle iterate request
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_data  out  9  {piece[2:0], rank[2:0], file[2:0]}
out_sop  out  1  first beat of iteration
out_eop  out  1  last beat of iteration
iter_done  out  1  one-cycle pulse when iteration completes, also for an empty list
count_w  out  CW  white entries stored
count_b  out  CW  black entries stored
overflow  out  1  sticky: a piece was dropped because its list was full
pos_err  out  1  sticky: malformed load

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except in_pos_ready = 1. Counts 0. Flags 0.
- Square index: a 6-bit counter. An accepted beat with sop is square 0; each later accepted beat increments it. rank = idx[5:3], file = idx[2:0].
- Beat accepted = in_pos_valid && in_pos_ready.
- States:
  - IDLE: lists invalid; start ignored.
  - LOAD: entered on an accepted beat with sop, from IDLE, READY or LOAD. On entry: clear both counts, overflow and pos_err, then process that beat as square 0.
  - READY: lists valid.
  - ITER: streaming.
- Beat processing in LOAD:
  - Non-empty piece: append {piece, idx} to its colour list at position count, then count += 1.
  - If count == DEPTH: drop the piece and set overflow.
- Completion of a load:
  - eop with idx == 63 -> READY.
  - eop with idx != 63 -> IDLE, set pos_err.
  - Beat without sop while in IDLE/READY: ignored, set pos_err.
  - idx wrapping past 63 without eop -> IDLE, set pos_err.
- Iteration:
  - start in READY latches in_wtp and enters ITER. in_pos_ready drops in the same cycle. start in any other state is ignored.
  - A scanner walks the selected list.
    - ORDERED=0: indices 0..count-1, one per cycle.
    - ORDERED=1: for type t = 1..6, indices 0..count-1; an entry matches when its piece == t. Cost is one cycle per index examined.
  - A one-entry lookahead stage holds the next match. out_eop = 1 on the beat for which the scanner has exhausted with no further match.
  - First beat appears no earlier than 2 cycles after start.
  - ORDERED=0 with out_ready held high sustains 1 beat/cycle.
- Handshake:
  - out_data, out_sop and out_eop are registered and held stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
  - out_sop is asserted on exactly the first beat.
- Completion:
  - iter_done pulses the cycle after the eop transfer; state returns to READY. Lists are retained, so start may repeat.
  - Empty list (count 0): no beats; iter_done pulses 2 cycles after start.
- Simultaneous events: start plus a sop beat in READY -> the load wins, start is dropped. In ITER, in_pos_ready = 0, so load beats are not accepted.
- Reset mid-ITER: outputs clear immediately; IDLE.

Test Plan:
- Start position (white on ranks 0-1), ORDERED=0, in_wtp=1:
  - count_w = count_b = 16.
  - 16 beats; first {3,0,0} sop, second {5,0,1}, last {6,1,7} eop.
  - iter_done the following cycle.
- Same position, ORDERED=1, in_wtp=0:
  - first {1,7,4} sop, then {2,7,3}, {3,7,0}, {3,7,7}, {4,7,2}.
  - last {6,6,7} eop.
- Random out_ready (50%) on start position: the beat sequence is identical to the full-rate run; out_data is stable during every stall; no beat is lost or duplicated.
- Overflow, DEPTH=16: a position with 17 white pieces gives count_w = 16 and overflow = 1. The 17th piece in square order is absent from the stream. A new sop clears overflow.
- Malformed and empty cases:
  - eop at idx 10 -> pos_err = 1, IDLE, start ignored (no beats, no iter_done).
  - Valid position with only a white king at e1, in_wtp=0: no beats; iter_done 2 cycles after start.
- rst_n low during the 5th beat of ITER: out_valid = 0 asynchronously. After release: IDLE, counts 0, in_pos_ready = 1.
